// File: rtl/prog_loader.sv
// Program loader: receives an instruction image over a byte stream, writes it
// into the instruction memory, verifies an XOR checksum and releases the CPU.
// Stream format: count byte, then count x {hi, lo} instruction bytes, then one
// checksum byte equal to the XOR of every preceding byte of the stream.
// The instruction memory is also the CPU fetch memory (1-cycle registered read).
module prog_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic [15:0]       fetch_instr,
    output logic              cpu_hold,
    output logic              loaded,
    output logic              error
);

    localparam int DEPTH = 1 << ADDR_W;
    // Remaining-word counter must hold the full depth when the header byte is 0,
    // and never be narrower than the 8-bit header plus one bit.
    localparam int CNT_W = (ADDR_W >= 8) ? (ADDR_W + 1) : 9;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_HI,
        S_LO,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  remain_q, remain_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        chk_q, chk_d;
    logic [7:0]        hi_q, hi_d;

    logic              loaded_q, loaded_d;
    logic              error_q, error_d;
    logic              hold_q, hold_d;
    logic [15:0]       fetch_q;

    logic              accept;
    logic              mem_we;
    logic [CNT_W-1:0]  hdr_count;

    logic [15:0]       mem [DEPTH];

    // A header byte of zero means a full-depth image.
    assign hdr_count = (rx_data == 8'h00) ? CNT_W'(DEPTH) : CNT_W'(rx_data);
    assign accept    = rx_valid && rx_ready;

    // State register and load bookkeeping; reset abandons any load in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            remain_q <= '0;
            waddr_q  <= '0;
            chk_q    <= '0;
            hi_q     <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            waddr_q  <= waddr_d;
            chk_q    <= chk_d;
            hi_q     <= hi_d;
        end
    end

    // Next-state and counter update; everything holds while no byte is accepted.
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        waddr_d  = waddr_q;
        chk_d    = chk_q;
        hi_d     = hi_q;
        unique case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                // Start is only honoured when no load is running.
                if (start) begin
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (accept) begin
                    remain_d = hdr_count;
                    waddr_d  = '0;
                    chk_d    = rx_data;
                    state_d  = S_HI;
                end
            end
            S_HI: begin
                if (accept) begin
                    hi_d    = rx_data;
                    chk_d   = chk_q ^ rx_data;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                if (accept) begin
                    chk_d    = chk_q ^ rx_data;
                    waddr_d  = waddr_q + ADDR_W'(1);
                    remain_d = remain_q - CNT_W'(1);
                    state_d  = (remain_q == CNT_W'(1)) ? S_CHK : S_HI;
                end
            end
            S_CHK: begin
                if (accept) begin
                    state_d = (rx_data == chk_q) ? S_DONE : S_ERR;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode: handshake from the current state, status flags from the
    // state being entered so they can be registered without input-to-output paths.
    always_comb begin
        rx_ready = 1'b0;
        mem_we   = 1'b0;
        loaded_d = 1'b0;
        error_d  = 1'b0;
        hold_d   = 1'b1;
        unique case (state_q)
            S_HDR, S_HI, S_LO, S_CHK: rx_ready = 1'b1;
            default:                  rx_ready = 1'b0;
        endcase
        // Reset must win over a pending write in the same cycle.
        mem_we = (state_q == S_LO) && rx_valid && !reset;
        unique case (state_d)
            S_DONE: begin
                loaded_d = 1'b1;
                error_d  = 1'b0;
                hold_d   = 1'b0;
            end
            S_ERR: begin
                loaded_d = 1'b0;
                error_d  = 1'b1;
                hold_d   = 1'b1;
            end
            default: begin
                loaded_d = 1'b0;
                error_d  = 1'b0;
                hold_d   = 1'b1;
            end
        endcase
    end

    // Registered status flags; the CPU stays held out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            loaded_q <= 1'b0;
            error_q  <= 1'b0;
            hold_q   <= 1'b1;
        end else begin
            loaded_q <= loaded_d;
            error_q  <= error_d;
            hold_q   <= hold_d;
        end
    end

    // Instruction memory write port; no reset, and words survive a failed checksum.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[waddr_q] <= {hi_q, rx_data};
        end
    end

    // Fetch port: registered read in every state, returns the old word on a
    // same-edge write to the same address.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_q <= 16'h0000;
        end else begin
            fetch_q <= mem[fetch_addr];
        end
    end

    assign fetch_instr = fetch_q;
    assign cpu_hold    = hold_q;
    assign loaded      = loaded_q;
    assign error       = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: drives byte streams, keeps a reference image
// of the instruction memory and checks status flags and fetch reads.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic [7:0]  fetch_addr;
    logic [15:0] fetch_instr;
    logic        cpu_hold;
    logic        loaded;
    logic        error;

    int n_checks = 0;
    int n_err    = 0;

    logic [15:0] ref_mem [256];
    logic [15:0] ld_words [$];
    logic [15:0] exp_q [$];
    string       tag_q [$];

    always #5 clk = ~clk;

    prog_loader #(.ADDR_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .fetch_addr (fetch_addr),
        .fetch_instr(fetch_instr),
        .cpu_hold   (cpu_hold),
        .loaded     (loaded),
        .error      (error)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic rdy, input logic hold,
                                input logic ld, input logic er);
        check({tag, "_rx_ready"}, {15'd0, rx_ready}, {15'd0, rdy});
        check({tag, "_cpu_hold"}, {15'd0, cpu_hold}, {15'd0, hold});
        check({tag, "_loaded"},   {15'd0, loaded},   {15'd0, ld});
        check({tag, "_error"},    {15'd0, error},    {15'd0, er});
    endtask

    // Fetch read through the scoreboard: expectation queued with the request,
    // compared when the registered word appears one cycle later.
    task automatic rd(input logic [7:0] addr, input string tag);
        exp_q.push_back(ref_mem[addr]);
        tag_q.push_back(tag);
        fetch_addr = addr;
        tick();
        check(tag_q.pop_front(), fetch_instr, exp_q.pop_front());
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stall);
        if (stall) begin
            rx_valid = 1'b0;
            rx_data  = 8'hXX;
            tick();
        end
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    // Sends the image in ld_words with a checksum computed from the bytes sent.
    task automatic do_load(input string tag, input bit stall, input bit bad,
                           input logic [7:0] bad_byte, input bit start_in_hi);
        int          n;
        logic [7:0]  hdr;
        logic [7:0]  cs;
        logic [7:0]  wa;
        logic [15:0] w;
        n   = ld_words.size();
        hdr = n[7:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        check_status({tag, "_start"}, 1'b1, 1'b1, 1'b0, 1'b0);
        cs = hdr;
        wa = 8'd0;
        send_byte(hdr, stall);
        for (int i = 0; i < n; i++) begin
            w = ld_words[i];
            send_byte(w[15:8], stall);
            if (i == 0 && start_in_hi) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            send_byte(w[7:0], stall);
            cs = cs ^ w[15:8] ^ w[7:0];
            ref_mem[wa] = w;
            wa = wa + 8'd1;
        end
        check({tag, "_pre_chk_ready"}, {15'd0, rx_ready}, 16'd1);
        send_byte(bad ? bad_byte : cs, stall);
        check_status({tag, "_end"}, 1'b0, bad, !bad, bad);
    endtask

    initial begin
        logic [7:0] b;
        reset      = 1'b1;
        start      = 1'b1;
        rx_valid   = 1'b1;
        rx_data    = 8'h55;
        fetch_addr = 8'd0;

        // Reset overrides start and rx_valid.
        tick();
        tick();
        check_status("reset", 1'b0, 1'b1, 1'b0, 1'b0);
        check("reset_fetch", fetch_instr, 16'h0000);
        reset    = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b1;
        tick();
        check_status("idle_no_accept", 1'b0, 1'b1, 1'b0, 1'b0);
        rx_valid = 1'b0;

        // Preload three known words.
        ld_words = '{16'h1111, 16'h2222, 16'h3333};
        do_load("pre", 1'b0, 1'b0, 8'h00, 1'b0);

        // Good two-word load.
        ld_words = '{16'h1234, 16'hABCD};
        do_load("good", 1'b0, 1'b0, 8'h00, 1'b0);
        rd(8'd0, "good_m0");
        rd(8'd1, "good_m1");
        rd(8'd2, "good_m2_untouched");

        // Bad checksum: words stay written.
        ld_words = '{16'h1234, 16'hABCD};
        do_load("bad", 1'b0, 1'b1, 8'h41, 1'b0);
        rd(8'd0, "bad_m0");

        // Stalls between bytes and start pulsed in HI.
        ld_words = '{16'h1234, 16'hABCD};
        do_load("stall", 1'b1, 1'b0, 8'h00, 1'b1);
        rd(8'd0, "stall_m0");
        rd(8'd1, "stall_m1");
        rd(8'd2, "stall_m2_untouched");

        // Full-depth load via header 0.
        ld_words.delete();
        for (int i = 0; i < 256; i++) begin
            b = i[7:0];
            ld_words.push_back({b, ~b});
        end
        do_load("full", 1'b0, 1'b0, 8'h00, 1'b0);
        rd(8'd0,   "full_m0");
        rd(8'd128, "full_m128");
        rd(8'd255, "full_m255");

        // Reset after the second data byte.
        start = 1'b1;
        tick();
        start = 1'b0;
        send_byte(8'h02, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        ref_mem[0] = 16'h1234;
        fetch_addr = 8'd255;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_status("midrst", 1'b0, 1'b1, 1'b0, 1'b0);
        check("midrst_fetch", fetch_instr, 16'h0000);
        rx_valid = 1'b1;
        rx_data  = 8'h12;
        tick();
        rx_valid = 1'b0;
        check_status("midrst_idle", 1'b0, 1'b1, 1'b0, 1'b0);
        rd(8'd255, "midrst_m255_kept");
        rd(8'd0,   "midrst_m0_written");
        ld_words = '{16'h1234, 16'hABCD};
        do_load("after_rst", 1'b0, 1'b0, 8'h00, 1'b0);
        rd(8'd0, "after_rst_m0");
        rd(8'd1, "after_rst_m1");

        // Reload from DONE, with a same-edge read of the address being written.
        start = 1'b1;
        tick();
        start = 1'b0;
        check_status("reload_start", 1'b1, 1'b1, 1'b0, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'hBE, 1'b0);
        fetch_addr = 8'd0;
        exp_q.push_back(ref_mem[0]);
        tag_q.push_back("reload_read_before_write");
        rx_valid = 1'b1;
        rx_data  = 8'hEF;
        tick();
        rx_valid = 1'b0;
        check(tag_q.pop_front(), fetch_instr, exp_q.pop_front());
        ref_mem[0] = 16'hBEEF;
        send_byte(8'h01 ^ 8'hBE ^ 8'hEF, 1'b0);
        check_status("reload_end", 1'b0, 1'b0, 1'b1, 1'b0);
        rd(8'd0, "reload_m0");
        rd(8'd1, "reload_m1");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
